// File: rtl/lsu_access_unit.sv
// lsu_access_unit: MEM-stage load/store unit. It takes one request at a time
// from EX, runs a request/grant/response bus transaction, steers store byte
// lanes, extracts and extends load data, and returns a registered response
// with an error code. The pipeline is stalled while a transaction is open.
module lsu_access_unit #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int TAG_WIDTH  = 5,
  parameter int MAX_WAIT   = 255
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_write,
  input  logic [1:0]              req_size,
  input  logic                    req_sign_ext,
  input  logic [ADDR_WIDTH-1:0]   req_addr,
  input  logic [DATA_WIDTH-1:0]   req_wdata,
  input  logic [TAG_WIDTH-1:0]    req_tag,
  output logic                    stall,
  output logic                    bus_req,
  output logic [DATA_WIDTH/8-1:0] bus_we,
  output logic [ADDR_WIDTH-1:0]   bus_addr,
  output logic [DATA_WIDTH-1:0]   bus_wdata,
  input  logic                    bus_gnt,
  input  logic                    bus_rvalid,
  input  logic [DATA_WIDTH-1:0]   bus_rdata,
  output logic                    resp_valid,
  output logic [DATA_WIDTH-1:0]   resp_data,
  output logic [TAG_WIDTH-1:0]    resp_tag,
  output logic [1:0]              resp_err
);

  localparam int NB    = DATA_WIDTH / 8;
  localparam int OFF_W = $clog2(NB);
  localparam int CNT_W = $clog2(MAX_WAIT + 1);

  localparam logic [1:0] ERR_OK      = 2'd0;
  localparam logic [1:0] ERR_ALIGN   = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT = 2'd2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    RESP = 2'd3
  } state_t;

  state_t state, state_nxt;

  // Per-request context captured at accept
  logic [1:0]           size_q;
  logic                 sign_q;
  logic                 write_q;
  logic [TAG_WIDTH-1:0] tag_q;
  logic [OFF_W-1:0]     off_q;
  logic [CNT_W-1:0]     cnt_q;

  logic [NB-1:0]         bus_we_q;
  logic [ADDR_WIDTH-1:0] bus_addr_q;
  logic [DATA_WIDTH-1:0] bus_wdata_q;
  logic [DATA_WIDTH-1:0] resp_data_q;
  logic [TAG_WIDTH-1:0]  resp_tag_q;
  logic [1:0]            resp_err_q;

  // Request-side derived values
  logic                  accept;
  logic [OFF_W-1:0]      req_off;
  logic                  req_bad;
  logic [NB-1:0]         req_mask;
  logic [NB-1:0]         req_we;
  logic [DATA_WIDTH-1:0] req_wdata_sh;
  logic [ADDR_WIDTH-1:0] req_addr_al;

  // Load-side derived values
  logic [DATA_WIDTH-1:0] rd_shifted;
  logic [DATA_WIDTH-1:0] rd_mask;
  logic                  rd_msb;
  logic [DATA_WIDTH-1:0] rd_ext;

  // Response staging
  logic                  timeout;
  logic                  resp_load;
  logic [DATA_WIDTH-1:0] resp_data_nxt;
  logic [TAG_WIDTH-1:0]  resp_tag_nxt;
  logic [1:0]            resp_err_nxt;

  assign accept  = req_valid && (state == IDLE);
  assign req_off = req_addr[OFF_W-1:0];
  assign timeout = (cnt_q == CNT_W'(MAX_WAIT - 1));

  // Store lane steering, alignment check and bus address alignment
  always_comb begin
    req_bad = 1'b0;
    case (req_size)
      2'd0:    req_bad = 1'b0;
      2'd1:    req_bad = req_off[0];
      2'd2:    req_bad = |req_off[1:0];
      default: req_bad = (DATA_WIDTH != 64) || (|req_off);
    endcase
    req_mask     = NB'((32'd1 << (32'd1 << req_size)) - 32'd1);
    req_we       = req_write ? (req_mask << req_off) : '0;
    req_wdata_sh = req_wdata << {req_off, 3'b000};
    req_addr_al  = {req_addr[ADDR_WIDTH-1:OFF_W], {OFF_W{1'b0}}};
  end

  // Load data extraction: shift lane down, mask to size, extend
  always_comb begin
    rd_shifted = bus_rdata >> {off_q, 3'b000};
    rd_mask    = '1;
    rd_msb     = 1'b0;
    case (size_q)
      2'd0: begin
        rd_mask = DATA_WIDTH'(8'hFF);
        rd_msb  = rd_shifted[7];
      end
      2'd1: begin
        rd_mask = DATA_WIDTH'(16'hFFFF);
        rd_msb  = rd_shifted[15];
      end
      2'd2: begin
        rd_mask = DATA_WIDTH'(32'hFFFF_FFFF);
        rd_msb  = rd_shifted[31];
      end
      default: begin
        rd_mask = '1;
        rd_msb  = 1'b0;
      end
    endcase
    rd_ext = (rd_shifted & rd_mask) | ((sign_q && rd_msb) ? ~rd_mask : '0);
  end

  // Next-state logic and response staging
  always_comb begin
    state_nxt     = state;
    resp_load     = 1'b0;
    resp_data_nxt = '0;
    resp_tag_nxt  = tag_q;
    resp_err_nxt  = ERR_OK;
    case (state)
      IDLE: begin
        if (accept) begin
          if (req_bad) begin
            state_nxt    = RESP;
            resp_load    = 1'b1;
            resp_tag_nxt = req_tag;
            resp_err_nxt = ERR_ALIGN;
          end else begin
            state_nxt = REQ;
          end
        end
      end
      REQ: begin
        if (timeout) begin
          state_nxt    = RESP;
          resp_load    = 1'b1;
          resp_err_nxt = ERR_TIMEOUT;
        end else if (bus_gnt) begin
          state_nxt = WAIT;
        end
      end
      WAIT: begin
        // Completion wins over a timeout landing in the same cycle
        if (bus_rvalid) begin
          state_nxt     = RESP;
          resp_load     = 1'b1;
          resp_data_nxt = write_q ? '0 : rd_ext;
        end else if (timeout) begin
          state_nxt    = RESP;
          resp_load    = 1'b1;
          resp_err_nxt = ERR_TIMEOUT;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // State, request context, bus drive and response registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= IDLE;
      size_q      <= '0;
      sign_q      <= 1'b0;
      write_q     <= 1'b0;
      tag_q       <= '0;
      off_q       <= '0;
      cnt_q       <= '0;
      bus_we_q    <= '0;
      bus_addr_q  <= '0;
      bus_wdata_q <= '0;
      resp_data_q <= '0;
      resp_tag_q  <= '0;
      resp_err_q  <= ERR_OK;
    end else begin
      state <= state_nxt;
      if (accept) begin
        size_q      <= req_size;
        sign_q      <= req_sign_ext;
        write_q     <= req_write;
        tag_q       <= req_tag;
        off_q       <= req_off;
        cnt_q       <= '0;
        bus_we_q    <= req_we;
        bus_addr_q  <= req_addr_al;
        bus_wdata_q <= req_wdata_sh;
      end else if (state == REQ || state == WAIT) begin
        cnt_q <= cnt_q + 1'b1;
      end
      if (resp_load) begin
        resp_data_q <= resp_data_nxt;
        resp_tag_q  <= resp_tag_nxt;
        resp_err_q  <= resp_err_nxt;
      end
    end
  end

  assign req_ready  = (state == IDLE);
  assign stall      = (state != IDLE);
  assign bus_req    = (state == REQ);
  assign resp_valid = (state == RESP);
  assign bus_we     = bus_we_q;
  assign bus_addr   = bus_addr_q;
  assign bus_wdata  = bus_wdata_q;
  assign resp_data  = resp_data_q;
  assign resp_tag   = resp_tag_q;
  assign resp_err   = resp_err_q;

endmodule

// File: tb/tb_lsu_access_unit.sv
// Directed bench for lsu_access_unit: one 32-bit instance (MAX_WAIT=8) and
// one 64-bit instance, driven cycle by cycle with hand-computed expectations.
module tb_lsu_access_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  // 32-bit instance
  logic        req_valid, req_ready, req_write, req_sign_ext;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic [4:0]  req_tag;
  logic        stall, bus_req, bus_gnt, bus_rvalid;
  logic [3:0]  bus_we;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;
  logic        resp_valid;
  logic [31:0] resp_data;
  logic [4:0]  resp_tag;
  logic [1:0]  resp_err;

  // 64-bit instance
  logic        w_req_valid, w_req_ready, w_req_write, w_req_sign_ext;
  logic [1:0]  w_req_size;
  logic [31:0] w_req_addr;
  logic [63:0] w_req_wdata;
  logic [4:0]  w_req_tag;
  logic        w_stall, w_bus_req, w_bus_gnt, w_bus_rvalid;
  logic [7:0]  w_bus_we;
  logic [31:0] w_bus_addr;
  logic [63:0] w_bus_wdata, w_bus_rdata;
  logic        w_resp_valid;
  logic [63:0] w_resp_data;
  logic [4:0]  w_resp_tag;
  logic [1:0]  w_resp_err;

  int vecs = 0;
  int errs = 0;

  lsu_access_unit #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .TAG_WIDTH(5), .MAX_WAIT(8)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_size(req_size), .req_sign_ext(req_sign_ext), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_tag(req_tag), .stall(stall),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_gnt(bus_gnt), .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata),
    .resp_valid(resp_valid), .resp_data(resp_data), .resp_tag(resp_tag),
    .resp_err(resp_err)
  );

  lsu_access_unit #(.DATA_WIDTH(64), .ADDR_WIDTH(32), .TAG_WIDTH(5), .MAX_WAIT(8)) dut64 (
    .clk(clk), .rst(rst),
    .req_valid(w_req_valid), .req_ready(w_req_ready), .req_write(w_req_write),
    .req_size(w_req_size), .req_sign_ext(w_req_sign_ext), .req_addr(w_req_addr),
    .req_wdata(w_req_wdata), .req_tag(w_req_tag), .stall(w_stall),
    .bus_req(w_bus_req), .bus_we(w_bus_we), .bus_addr(w_bus_addr), .bus_wdata(w_bus_wdata),
    .bus_gnt(w_bus_gnt), .bus_rvalid(w_bus_rvalid), .bus_rdata(w_bus_rdata),
    .resp_valid(w_resp_valid), .resp_data(w_resp_data), .resp_tag(w_resp_tag),
    .resp_err(w_resp_err)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic wr, input logic [1:0] sz, input logic sx,
                       input logic [31:0] a, input logic [31:0] wd, input logic [4:0] tg);
    req_valid    = 1'b1;
    req_write    = wr;
    req_size     = sz;
    req_sign_ext = sx;
    req_addr     = a;
    req_wdata    = wd;
    req_tag      = tg;
  endtask

  task automatic issue64(input logic wr, input logic [1:0] sz, input logic sx,
                         input logic [31:0] a, input logic [63:0] wd, input logic [4:0] tg);
    w_req_valid    = 1'b1;
    w_req_write    = wr;
    w_req_size     = sz;
    w_req_sign_ext = sx;
    w_req_addr     = a;
    w_req_wdata    = wd;
    w_req_tag      = tg;
  endtask

  initial begin
    rst = 1'b0;
    req_valid = 1'b0; req_write = 1'b0; req_size = 2'd0; req_sign_ext = 1'b0;
    req_addr = '0; req_wdata = '0; req_tag = '0;
    bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_rdata = '0;
    w_req_valid = 1'b0; w_req_write = 1'b0; w_req_size = 2'd0; w_req_sign_ext = 1'b0;
    w_req_addr = '0; w_req_wdata = '0; w_req_tag = '0;
    w_bus_gnt = 1'b0; w_bus_rvalid = 1'b0; w_bus_rdata = '0;

    // ---- reset state
    step(); step();
    chk("rst_ready", req_ready, 1);
    chk("rst_stall", stall, 0);
    chk("rst_bus_req", bus_req, 0);
    chk("rst_bus_we", bus_we, 0);
    chk("rst_bus_addr", bus_addr, 0);
    chk("rst_bus_wdata", bus_wdata, 0);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_resp_data", resp_data, 0);
    chk("rst_resp_tag", resp_tag, 0);
    chk("rst_resp_err", resp_err, 0);
    chk("rst64_ready", w_req_ready, 1);
    rst = 1'b1;
    step();

    // ---- load byte signed at 0x1003, minimum latency
    issue(1'b0, 2'd0, 1'b1, 32'h1003, 32'h0, 5'd3);
    chk("lb_ready", req_ready, 1);
    step();
    req_valid = 1'b0;
    chk("lb_bus_req_c1", bus_req, 1);
    chk("lb_bus_addr", bus_addr, 32'h1000);
    chk("lb_bus_we", bus_we, 0);
    chk("lb_stall_c1", stall, 1);
    chk("lb_ready_c1", req_ready, 0);
    bus_gnt = 1'b1;
    step();
    bus_gnt = 1'b0;
    chk("lb_bus_req_c2", bus_req, 0);
    bus_rvalid = 1'b1; bus_rdata = 32'h80FF_1234;
    step();
    bus_rvalid = 1'b0;
    chk("lb_resp_valid_c3", resp_valid, 1);
    chk("lb_resp_data", resp_data, 32'hFFFF_FF80);
    chk("lb_resp_err", resp_err, 0);
    chk("lb_resp_tag", resp_tag, 3);
    step();
    chk("lb_resp_valid_c4", resp_valid, 0);
    chk("lb_ready_c4", req_ready, 1);

    // ---- store half at 0x2002, grant delayed, rvalid in grant cycle ignored
    issue(1'b1, 2'd1, 1'b0, 32'h2002, 32'h0000_ABCD, 5'd7);
    step();
    req_valid = 1'b0;
    chk("sh_bus_we", bus_we, 4'b1100);
    chk("sh_bus_wdata", bus_wdata, 32'hABCD_0000);
    chk("sh_bus_addr", bus_addr, 32'h2000);
    for (int i = 1; i <= 4; i++) begin
      chk("sh_bus_req_hold", bus_req, 1);
      chk("sh_stall_req", stall, 1);
      step();
    end
    chk("sh_bus_req_c5", bus_req, 1);
    bus_gnt = 1'b1; bus_rvalid = 1'b1; bus_rdata = 32'h1111_1111;
    step();
    bus_gnt = 1'b0; bus_rvalid = 1'b0;
    chk("sh_bus_req_c6", bus_req, 0);
    chk("sh_stall_c6", stall, 1);
    chk("sh_no_resp_c6", resp_valid, 0);
    step();
    chk("sh_no_resp_c7", resp_valid, 0);
    chk("sh_stall_c7", stall, 1);
    bus_rvalid = 1'b1; bus_rdata = 32'hDEAD_BEEF;
    step();
    bus_rvalid = 1'b0;
    chk("sh_resp_valid", resp_valid, 1);
    chk("sh_resp_data", resp_data, 0);
    chk("sh_resp_err", resp_err, 0);
    chk("sh_resp_tag", resp_tag, 7);
    chk("sh_stall_resp", stall, 1);
    step();
    chk("sh_stall_done", stall, 0);

    // ---- misaligned word load at 0x3001
    issue(1'b0, 2'd2, 1'b0, 32'h3001, 32'h0, 5'd9);
    step();
    req_valid = 1'b0;
    chk("mis_bus_req", bus_req, 0);
    chk("mis_resp_valid", resp_valid, 1);
    chk("mis_resp_err", resp_err, 1);
    chk("mis_resp_tag", resp_tag, 9);
    chk("mis_resp_data", resp_data, 0);
    step();
    chk("mis_resp_done", resp_valid, 0);
    chk("mis_ready", req_ready, 1);

    // ---- dword size on 32-bit instance is illegal
    issue(1'b0, 2'd3, 1'b0, 32'h9000, 32'h0, 5'd10);
    step();
    req_valid = 1'b0;
    chk("ill_resp_valid", resp_valid, 1);
    chk("ill_resp_err", resp_err, 1);
    chk("ill_bus_req", bus_req, 0);
    step();

    // ---- timeout: no grant with MAX_WAIT=8
    issue(1'b0, 2'd2, 1'b0, 32'h4000, 32'h0, 5'd11);
    step();
    req_valid = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      chk("to_bus_req_hold", bus_req, 1);
      chk("to_no_resp", resp_valid, 0);
      step();
    end
    chk("to_resp_valid_c9", resp_valid, 1);
    chk("to_resp_err", resp_err, 2);
    chk("to_resp_data", resp_data, 0);
    chk("to_resp_tag", resp_tag, 11);
    chk("to_bus_req_c9", bus_req, 0);
    bus_rvalid = 1'b1; bus_rdata = 32'h5555_5555;
    step();
    chk("to_late_rvalid_c10", resp_valid, 0);
    chk("to_ready_c10", req_ready, 1);
    step();
    bus_rvalid = 1'b0;
    chk("to_late_rvalid_c11", resp_valid, 0);
    chk("to_stall_c11", stall, 0);

    // ---- 64-bit: load half unsigned at offset 6
    issue64(1'b0, 2'd1, 1'b0, 32'h5006, 64'h0, 5'd4);
    chk("w_lh_ready", w_req_ready, 1);
    step();
    w_req_valid = 1'b0;
    chk("w_lh_bus_req", w_bus_req, 1);
    chk("w_lh_bus_addr", w_bus_addr, 32'h5000);
    chk("w_lh_bus_we", w_bus_we, 0);
    w_bus_gnt = 1'b1;
    step();
    w_bus_gnt = 1'b0;
    w_bus_rvalid = 1'b1; w_bus_rdata = 64'h8001_0000_0000_0000;
    step();
    w_bus_rvalid = 1'b0;
    chk("w_lh_resp_valid", w_resp_valid, 1);
    chk("w_lh_resp_data", w_resp_data, 64'h0000_0000_0000_8001);
    chk("w_lh_resp_err", w_resp_err, 0);
    chk("w_lh_resp_tag", w_resp_tag, 4);
    step();

    // ---- 64-bit: dword store at offset 0
    issue64(1'b1, 2'd3, 1'b0, 32'h6000, 64'h1122_3344_5566_7788, 5'd6);
    step();
    w_req_valid = 1'b0;
    chk("w_sd_bus_we", w_bus_we, 8'hFF);
    chk("w_sd_bus_wdata", w_bus_wdata, 64'h1122_3344_5566_7788);
    chk("w_sd_bus_req", w_bus_req, 1);
    w_bus_gnt = 1'b1;
    step();
    w_bus_gnt = 1'b0;
    w_bus_rvalid = 1'b1;
    step();
    w_bus_rvalid = 1'b0;
    chk("w_sd_resp_valid", w_resp_valid, 1);
    chk("w_sd_resp_data", w_resp_data, 0);
    chk("w_sd_resp_err", w_resp_err, 0);
    step();

    // ---- 64-bit: dword at offset 4 is misaligned
    issue64(1'b0, 2'd3, 1'b0, 32'h6004, 64'h0, 5'd8);
    step();
    w_req_valid = 1'b0;
    chk("w_md_resp_valid", w_resp_valid, 1);
    chk("w_md_resp_err", w_resp_err, 1);
    chk("w_md_bus_req", w_bus_req, 0);
    step();

    // ---- reset during WAIT
    issue(1'b0, 2'd2, 1'b0, 32'h7000, 32'h0, 5'd13);
    step();
    req_valid = 1'b0;
    bus_gnt = 1'b1;
    step();
    bus_gnt = 1'b0;
    chk("rw_in_wait", bus_req, 0);
    chk("rw_stall_wait", stall, 1);
    rst = 1'b0;
    step();
    rst = 1'b1;
    chk("rw_ready", req_ready, 1);
    chk("rw_stall", stall, 0);
    chk("rw_no_resp", resp_valid, 0);
    chk("rw_bus_addr", bus_addr, 0);
    step();
    chk("rw_no_resp_later", resp_valid, 0);

    // ---- back-to-back: second request held through RESP
    issue(1'b0, 2'd0, 1'b0, 32'h8001, 32'h0, 5'd1);
    step();
    req_valid = 1'b0;
    bus_gnt = 1'b1;
    step();
    bus_gnt = 1'b0;
    bus_rvalid = 1'b1; bus_rdata = 32'h0000_AB00;
    step();
    bus_rvalid = 1'b0;
    chk("bb_a_resp_valid", resp_valid, 1);
    chk("bb_a_resp_data", resp_data, 32'h0000_00AB);
    chk("bb_a_resp_tag", resp_tag, 1);
    issue(1'b0, 2'd0, 1'b1, 32'h8002, 32'h0, 5'd2);
    chk("bb_ready_in_resp", req_ready, 0);
    step();
    chk("bb_ready_idle", req_ready, 1);
    chk("bb_bus_req_idle", bus_req, 0);
    step();
    req_valid = 1'b0;
    chk("bb_b_bus_req", bus_req, 1);
    chk("bb_b_bus_addr", bus_addr, 32'h8000);
    bus_gnt = 1'b1;
    step();
    bus_gnt = 1'b0;
    bus_rvalid = 1'b1; bus_rdata = 32'h00CD_0000;
    step();
    bus_rvalid = 1'b0;
    chk("bb_b_resp_valid", resp_valid, 1);
    chk("bb_b_resp_data", resp_data, 32'hFFFF_FFCD);
    chk("bb_b_resp_tag", resp_tag, 2);
    step();
    chk("bb_b_done", resp_valid, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
